trng_multi_collector: RTL and testbench
=======================================

Name: trng_multi_collector

Overview:
- Parametrised successor to the single-source TRNG-to-FIFO front end. Collects words from NUM_CH independent entropy sources through per-channel holding registers and a round-robin arbiter into one first-word-fall-through (FWFT) FIFO.
- Provides a configurable pop mode (level or synchronised button edge), occupancy count, drop accounting and optional per-channel repetition health test.
- Sits between the entropy sources and the CPU MMIO read port or the button-driven output.

Parameters:
- WIDTH, 32: bits per entropy word.
- NUM_CH, 2: number of entropy sources, 1..8.
- DEPTH, 16: FIFO entries, power of two, >= 2.
- POP_EDGE, 0: 0 = pop every cycle rd_req is high; 1 = rd_req is 2-FF synchronised and pops once per rising edge.
- REP_LIMIT, 3: consecutive identical words per channel that trigger a health failure. Used only with TRNG_REPCOUNT_EN.

Ports:
- clk, input, 1: single clock.
- rst, input, 1: reset, synchronous, active-high.
- ch_data, input, NUM_CH*WIDTH: channel i occupies bits [i*WIDTH +: WIDTH].
- ch_valid, input, NUM_CH: one-cycle pulse per word; no backpressure to sources.
- rd_req, input, 1: pop request (CPU strobe or button).
- rd_data, output, WIDTH: FIFO head word, valid while !empty.
- empty, output, 1: FIFO empty.
- full, output, 1: FIFO full.
- count, output, $clog2(DEPTH)+1: occupancy.
- drop_flag, output, 1: sticky; set when any word is lost.
- drop_cnt, output, 16: saturating count of cycles with at least one lost word.
- health_fail, output, NUM_CH: sticky per-channel health failure.

Behaviour:
- Reset (synchronous, rst=1 at a clk edge) clears:
  - all holding registers, FIFO pointers and the arbiter pointer (channel 0 is highest priority first);
  - sync flops, drop_flag, drop_cnt and health_fail;
  - repetition state.
- Resulting output values: empty=1, full=0, count=0, rd_data=0.
- Reset mid-operation discards all queued words.
- Holding registers:
  - Each channel has a 1-entry hold (data plus hold_v).
  - A ch_valid pulse loads the hold if hold_v=0, or if the hold is being granted in the same cycle.
  - Otherwise the new word is discarded and the old word is kept. That cycle sets drop_flag and increments drop_cnt by 1, however many channels overflowed. drop_cnt saturates at 16'hFFFF.
- Arbiter:
  - Each cycle, if !full, grant exactly one channel with hold_v=1.
  - Search starts at last_grant+1 and wraps modulo NUM_CH.
  - A granted word is written to the FIFO at that edge, and last_grant updates.
  - When full=1, no grant occurs even if a pop happens in the same cycle; holds stay pending.
- Latency:
  - ch_valid at cycle t loads the hold at the end of t.
  - With the FIFO otherwise idle and no contention, the FIFO write occurs at the end of t+1.
  - empty falls and rd_data is valid in cycle t+2.
- Pop, POP_EDGE=0: pop when rd_req=1 and empty=0.
- Pop, POP_EDGE=1:
  - rd_req passes through 2 flops (s1, s2) plus a previous-value flop.
  - Pop when s2=1, the previous value was 0, and empty=0.
  - One press gives one pop, 3 cycles after rd_req rises.
- Pop when empty is ignored; state does not change.
- FIFO:
  - FWFT: rd_data always reflects the head and updates the cycle after a pop.
  - Pointers wrap modulo DEPTH.
  - Push and pop in the same cycle leave count unchanged.
  - full = (count==DEPTH), empty = (count==0).

Optional Feature:
- Macro TRNG_REPCOUNT_EN.
- Defined:
  - Per channel, keep the last word accepted into the hold and a repeat counter.
  - An arriving word equal to the last word increments the counter; an unequal word resets it to 0.
  - When the counter reaches REP_LIMIT-1 (the REP_LIMIT-th identical word), set health_fail[i].
  - While health_fail[i]=1, all words from channel i are discarded and not counted as drops.
  - The bit clears only on rst.
- Undefined: health_fail is tied to 0, no comparison logic is built, and every word is eligible.

Test Plan (WIDTH=32, NUM_CH=2, DEPTH=4):
- Reset then idle: rst=1 for 2 cycles -> empty=1, full=0, count=0, rd_data=0, drop_cnt=0, health_fail=0.
- Single word: ch_valid[0] pulse with 32'hA5A5_0001 at cycle t -> empty=0 and rd_data=A5A5_0001 at t+2. POP_EDGE=0 with rd_req for 1 cycle -> empty=1 the next cycle.
- Simultaneous pulses: ch0=32'h11, ch1=32'h22 in the same cycle -> FIFO order 11 then 22. Repeating the pulses -> 11, 22 again (round-robin alternates). count=4 and full=1.
- Full and drop: FIFO full, hold 0 occupied, another ch0 pulse -> drop_flag=1, drop_cnt=1, held word kept. Pop once -> the held word is written after the pop cycle, count returns to 4.
- POP_EDGE=1: 3 words queued, rd_req held high for 10 cycles -> exactly 1 pop (count 3->2), 3 cycles after the rising edge.
- TRNG_REPCOUNT_EN, REP_LIMIT=3: ch1 sends 32'hDEAD_BEEF three times -> health_fail=2'b10 after the 3rd; later ch1 words are discarded, ch0 is unaffected, drop_cnt unchanged.

Source files
------------

// File: rtl/trng_multi_collector_if.sv
// rtl/trng_multi_collector_if.sv - read-side bundle between the entropy collector and its consumer
//
// Purpose : groups the pop request and the FIFO head/status signals.
// Signals : rd_req  - pop request (CPU strobe or button)
//           rd_data - FIFO head word, valid while !empty
//           empty   - FIFO empty
//           full    - FIFO full
//           count   - FIFO occupancy, $clog2(DEPTH)+1 bits
// Modports: master - consumer side (drives rd_req)
//           slave  - collector side (drives data and status)
interface trng_multi_collector_if #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 16
) ();
    logic                     rd_req;
    logic [WIDTH-1:0]         rd_data;
    logic                     empty;
    logic                     full;
    logic [$clog2(DEPTH):0]   count;

    modport master (output rd_req, input rd_data, input empty, input full, input count);
    modport slave  (input rd_req, output rd_data, output empty, output full, output count);
endinterface

// File: rtl/trng_multi_collector.sv
// rtl/trng_multi_collector.sv - multi-channel TRNG collector with round-robin arbiter and FWFT FIFO
//
// Purpose : collects words from NUM_CH entropy sources through 1-entry holding
//           registers and a round-robin arbiter into one FWFT FIFO, with drop
//           accounting and an optional per-channel repetition health test.
// Ports   : clk         - clock
//           rst         - synchronous active-high reset
//           ch_data     - NUM_CH*WIDTH source words, channel i at [i*WIDTH +: WIDTH]
//           ch_valid    - per-channel one-cycle word strobe, no backpressure
//           rd_if       - slave modport: rd_req in; rd_data/empty/full/count out
//           drop_flag   - sticky, set when any word is lost
//           drop_cnt    - saturating count of cycles that lost at least one word
//           health_fail - sticky per-channel repetition failure
// Options : define TRNG_REPCOUNT_EN to build the repetition health test;
//           otherwise health_fail is tied to zero.
module trng_multi_collector #(
    parameter int WIDTH     = 32,
    parameter int NUM_CH    = 2,
    parameter int DEPTH     = 16,
    parameter int POP_EDGE  = 0,
    parameter int REP_LIMIT = 3
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [NUM_CH*WIDTH-1:0]  ch_data,
    input  logic [NUM_CH-1:0]        ch_valid,
    trng_multi_collector_if.slave    rd_if,
    output logic                     drop_flag,
    output logic [15:0]              drop_cnt,
    output logic [NUM_CH-1:0]        health_fail
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH) + 1;
    localparam int CH_W  = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

    // holding registers
    logic [WIDTH-1:0]  hold_data_q [NUM_CH];
    logic [WIDTH-1:0]  hold_data_d [NUM_CH];
    logic [NUM_CH-1:0] hold_v_q, hold_v_d;
    logic [NUM_CH-1:0] load_vec;
    logic [NUM_CH-1:0] eligible;
    logic              drop_any;

    // arbiter
    logic [CH_W-1:0]   last_grant_q, last_grant_d;
    logic              grant_v;
    logic [CH_W-1:0]   grant_idx;
    logic [NUM_CH-1:0] grant_vec;
    int                rr_idx;

    // FIFO
    logic [WIDTH-1:0]  mem_q [DEPTH];
    logic [WIDTH-1:0]  mem_d [DEPTH];
    logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]  count_q, count_d;
    logic              full_w, empty_w;
    logic              push, pop_req, do_pop;

    // pop synchroniser and drop accounting
    logic              s1_q, s1_d, s2_q, s2_d, prev_q, prev_d;
    logic              drop_flag_q, drop_flag_d;
    logic [15:0]       drop_cnt_q, drop_cnt_d;

    assign full_w  = (count_q == CNT_W'(DEPTH));
    assign empty_w = (count_q == '0);

    // Round-robin search starting one past the last grant; no grant while full
    // even if a pop happens this cycle, so a held word waits one extra cycle.
    always_comb begin
        grant_v   = 1'b0;
        grant_idx = '0;
        rr_idx    = 0;
        if (!full_w) begin
            for (int k = 0; k < NUM_CH; k++) begin
                rr_idx = int'(last_grant_q) + 1 + k;
                if (rr_idx >= NUM_CH) rr_idx = rr_idx - NUM_CH;
                if (rr_idx >= NUM_CH) rr_idx = rr_idx - NUM_CH;
                if (!grant_v && hold_v_q[rr_idx]) begin
                    grant_v   = 1'b1;
                    grant_idx = CH_W'(rr_idx);
                end
            end
        end
        for (int i = 0; i < NUM_CH; i++) begin
            grant_vec[i] = grant_v && (grant_idx == CH_W'(i));
        end
    end

    // Edge mode pops on the rising edge of the synchronised request only.
    assign pop_req = (POP_EDGE != 0) ? (s2_q && !prev_q) : rd_if.rd_req;
    assign do_pop  = pop_req && !empty_w;
    assign push    = grant_v;

    always_comb begin
        hold_data_d  = hold_data_q;
        hold_v_d     = hold_v_q;
        load_vec     = '0;
        drop_any     = 1'b0;
        mem_d        = mem_q;
        wr_ptr_d     = wr_ptr_q;
        rd_ptr_d     = rd_ptr_q;
        count_d      = count_q;
        last_grant_d = last_grant_q;
        drop_flag_d  = drop_flag_q;
        drop_cnt_d   = drop_cnt_q;
        s1_d         = rd_if.rd_req;
        s2_d         = s1_q;
        prev_d       = s2_q;

        for (int i = 0; i < NUM_CH; i++) begin
            if (grant_vec[i]) hold_v_d[i] = 1'b0;
            if (ch_valid[i] && eligible[i]) begin
                // A hold being granted this cycle is free to take the new word.
                if (!hold_v_q[i] || grant_vec[i]) begin
                    hold_data_d[i] = ch_data[i*WIDTH +: WIDTH];
                    hold_v_d[i]    = 1'b1;
                    load_vec[i]    = 1'b1;
                end else begin
                    drop_any = 1'b1;
                end
            end
        end

        if (drop_any) begin
            drop_flag_d = 1'b1;
            if (drop_cnt_q != 16'hFFFF) drop_cnt_d = drop_cnt_q + 16'd1;
        end

        if (push) begin
            mem_d[wr_ptr_q] = hold_data_q[grant_idx];
            wr_ptr_d        = wr_ptr_q + PTR_W'(1);
            last_grant_d    = grant_idx;
        end
        if (do_pop) rd_ptr_d = rd_ptr_q + PTR_W'(1);

        case ({push, do_pop})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NUM_CH; i++) hold_data_q[i] <= '0;
            hold_v_q     <= '0;
            last_grant_q <= CH_W'(NUM_CH - 1);
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            count_q      <= '0;
            drop_flag_q  <= 1'b0;
            drop_cnt_q   <= '0;
            s1_q         <= 1'b0;
            s2_q         <= 1'b0;
            prev_q       <= 1'b0;
        end else begin
            hold_data_q  <= hold_data_d;
            hold_v_q     <= hold_v_d;
            last_grant_q <= last_grant_d;
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            count_q      <= count_d;
            drop_flag_q  <= drop_flag_d;
            drop_cnt_q   <= drop_cnt_d;
            s1_q         <= s1_d;
            s2_q         <= s2_d;
            prev_q       <= prev_d;
        end
    end

    // Storage needs no reset: rd_data is masked while empty.
    always_ff @(posedge clk) begin
        mem_q <= mem_d;
    end

`ifdef TRNG_REPCOUNT_EN
    localparam int REP_W = $clog2(REP_LIMIT) + 1;

    logic [WIDTH-1:0]  rep_last_q [NUM_CH];
    logic [WIDTH-1:0]  rep_last_d [NUM_CH];
    logic [REP_W-1:0]  rep_cnt_q  [NUM_CH];
    logic [REP_W-1:0]  rep_cnt_d  [NUM_CH];
    logic [NUM_CH-1:0] rep_v_q, rep_v_d;
    logic [NUM_CH-1:0] health_fail_q, health_fail_d;

    // Compares each word accepted into the hold against the previous accepted
    // word; rep_v_q keeps the very first word from matching the reset value.
    always_comb begin
        rep_last_d    = rep_last_q;
        rep_cnt_d     = rep_cnt_q;
        rep_v_d       = rep_v_q;
        health_fail_d = health_fail_q;
        for (int i = 0; i < NUM_CH; i++) begin
            if (load_vec[i]) begin
                if (rep_v_q[i] && (ch_data[i*WIDTH +: WIDTH] == rep_last_q[i])) begin
                    if (rep_cnt_q[i] != REP_W'(REP_LIMIT - 1))
                        rep_cnt_d[i] = rep_cnt_q[i] + REP_W'(1);
                end else begin
                    rep_cnt_d[i] = '0;
                end
                rep_last_d[i] = ch_data[i*WIDTH +: WIDTH];
                rep_v_d[i]    = 1'b1;
                if (rep_cnt_d[i] == REP_W'(REP_LIMIT - 1)) health_fail_d[i] = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NUM_CH; i++) begin
                rep_last_q[i] <= '0;
                rep_cnt_q[i]  <= '0;
            end
            rep_v_q       <= '0;
            health_fail_q <= '0;
        end else begin
            rep_last_q    <= rep_last_d;
            rep_cnt_q     <= rep_cnt_d;
            rep_v_q       <= rep_v_d;
            health_fail_q <= health_fail_d;
        end
    end

    assign eligible    = ~health_fail_q;
    assign health_fail = health_fail_q;
`else
    assign eligible    = '1;
    assign health_fail = '0;
`endif

    assign rd_if.rd_data = empty_w ? '0 : mem_q[rd_ptr_q];
    assign rd_if.empty   = empty_w;
    assign rd_if.full    = full_w;
    assign rd_if.count   = count_q;
    assign drop_flag     = drop_flag_q;
    assign drop_cnt      = drop_cnt_q;

endmodule

// File: tb/tb_trng_multi_collector.sv
// tb/tb_trng_multi_collector.sv - directed self-checking bench for trng_multi_collector
module tb_trng_multi_collector;
    localparam int W = 32;
    localparam int N = 2;
    localparam int D = 4;

    logic           clk = 1'b0;
    logic           rst;
    logic [N*W-1:0] ch_data;
    logic [N-1:0]   ch_valid;
    logic           drop_flag0, drop_flag1;
    logic [15:0]    drop_cnt0, drop_cnt1;
    logic [N-1:0]   health_fail0, health_fail1;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    trng_multi_collector_if #(.WIDTH(W), .DEPTH(D)) if0 ();
    trng_multi_collector_if #(.WIDTH(W), .DEPTH(D)) if1 ();

    trng_multi_collector #(.WIDTH(W), .NUM_CH(N), .DEPTH(D), .POP_EDGE(0), .REP_LIMIT(3)) dut0 (
        .clk(clk), .rst(rst), .ch_data(ch_data), .ch_valid(ch_valid), .rd_if(if0.slave),
        .drop_flag(drop_flag0), .drop_cnt(drop_cnt0), .health_fail(health_fail0)
    );

    trng_multi_collector #(.WIDTH(W), .NUM_CH(N), .DEPTH(D), .POP_EDGE(1), .REP_LIMIT(3)) dut1 (
        .clk(clk), .rst(rst), .ch_data(ch_data), .ch_valid(ch_valid), .rd_if(if1.slave),
        .drop_flag(drop_flag1), .drop_cnt(drop_cnt1), .health_fail(health_fail1)
    );

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset;
        rst = 1'b1;
        ch_valid = '0;
        if0.rd_req = 1'b0;
        if1.rd_req = 1'b0;
        tick();
        tick();
        rst = 1'b0;
    endtask

    task automatic test_reset;
        ch_data = '0;
        do_reset();
        checks++; if (if0.empty !== 1'b1) begin errors++; $display("FAIL reset_empty got %0b exp 1", if0.empty); end
        checks++; if (if0.full !== 1'b0) begin errors++; $display("FAIL reset_full got %0b exp 0", if0.full); end
        checks++; if (if0.count !== 3'd0) begin errors++; $display("FAIL reset_count got %0d exp 0", if0.count); end
        checks++; if (if0.rd_data !== 32'h0) begin errors++; $display("FAIL reset_rd_data got %h exp 0", if0.rd_data); end
        checks++; if (drop_cnt0 !== 16'd0) begin errors++; $display("FAIL reset_drop_cnt got %0d exp 0", drop_cnt0); end
        checks++; if (drop_flag0 !== 1'b0) begin errors++; $display("FAIL reset_drop_flag got %0b exp 0", drop_flag0); end
        checks++; if (health_fail0 !== 2'b00) begin errors++; $display("FAIL reset_health got %b exp 00", health_fail0); end
    endtask

    task automatic test_single_word;
        ch_data[31:0] = 32'hA5A5_0001;
        ch_valid = 2'b01;
        tick();
        ch_valid = 2'b00;
        checks++; if (if0.empty !== 1'b1) begin errors++; $display("FAIL single_t1_empty got %0b exp 1", if0.empty); end
        tick();
        checks++; if (if0.empty !== 1'b0) begin errors++; $display("FAIL single_t2_empty got %0b exp 0", if0.empty); end
        checks++; if (if0.rd_data !== 32'hA5A5_0001) begin errors++; $display("FAIL single_rd_data got %h exp a5a50001", if0.rd_data); end
        checks++; if (if0.count !== 3'd1) begin errors++; $display("FAIL single_count got %0d exp 1", if0.count); end
        if0.rd_req = 1'b1;
        tick();
        if0.rd_req = 1'b0;
        checks++; if (if0.empty !== 1'b1) begin errors++; $display("FAIL single_pop_empty got %0b exp 1", if0.empty); end
        checks++; if (if0.rd_data !== 32'h0) begin errors++; $display("FAIL single_pop_rd_data got %h exp 0", if0.rd_data); end
    endtask

    task automatic test_simultaneous;
        do_reset();
        ch_data = {32'h22, 32'h11};
        ch_valid = 2'b11;
        tick();
        ch_valid = 2'b00;
        tick();
        tick();
        checks++; if (if0.count !== 3'd2) begin errors++; $display("FAIL simul_count2 got %0d exp 2", if0.count); end
        checks++; if (if0.rd_data !== 32'h11) begin errors++; $display("FAIL simul_head got %h exp 11", if0.rd_data); end
        ch_valid = 2'b11;
        tick();
        ch_valid = 2'b00;
        tick();
        tick();
        checks++; if (if0.count !== 3'd4) begin errors++; $display("FAIL simul_count4 got %0d exp 4", if0.count); end
        checks++; if (if0.full !== 1'b1) begin errors++; $display("FAIL simul_full got %0b exp 1", if0.full); end
    endtask

    task automatic test_full_drop;
        logic [31:0] exp_q [4];
        exp_q[0] = 32'h22; exp_q[1] = 32'h11; exp_q[2] = 32'h22; exp_q[3] = 32'h33;
        ch_data[31:0] = 32'h33;
        ch_valid = 2'b01;
        tick();
        ch_valid = 2'b00;
        tick();
        checks++; if (drop_flag0 !== 1'b0) begin errors++; $display("FAIL full_no_drop got %0b exp 0", drop_flag0); end
        ch_data[31:0] = 32'h44;
        ch_valid = 2'b01;
        tick();
        ch_valid = 2'b00;
        checks++; if (drop_flag0 !== 1'b1) begin errors++; $display("FAIL drop_flag got %0b exp 1", drop_flag0); end
        checks++; if (drop_cnt0 !== 16'd1) begin errors++; $display("FAIL drop_cnt got %0d exp 1", drop_cnt0); end
        checks++; if (if0.count !== 3'd4) begin errors++; $display("FAIL drop_count got %0d exp 4", if0.count); end
        if0.rd_req = 1'b1;
        tick();
        if0.rd_req = 1'b0;
        checks++; if (if0.count !== 3'd3) begin errors++; $display("FAIL popfull_count got %0d exp 3", if0.count); end
        checks++; if (if0.rd_data !== 32'h22) begin errors++; $display("FAIL popfull_head got %h exp 22", if0.rd_data); end
        tick();
        checks++; if (if0.count !== 3'd4) begin errors++; $display("FAIL refill_count got %0d exp 4", if0.count); end
        for (int k = 0; k < 4; k++) begin
            checks++; if (if0.rd_data !== exp_q[k]) begin errors++; $display("FAIL drain_%0d got %h exp %h", k, if0.rd_data, exp_q[k]); end
            if0.rd_req = 1'b1;
            tick();
            if0.rd_req = 1'b0;
        end
        if0.rd_req = 1'b1;
        tick();
        tick();
        if0.rd_req = 1'b0;
        checks++; if (if0.empty !== 1'b1) begin errors++; $display("FAIL pop_empty_ignored got %0b exp 1", if0.empty); end
        checks++; if (if0.count !== 3'd0) begin errors++; $display("FAIL pop_empty_count got %0d exp 0", if0.count); end
        checks++; if (drop_cnt0 !== 16'd1) begin errors++; $display("FAIL drop_cnt_after got %0d exp 1", drop_cnt0); end
    endtask

    task automatic test_pop_edge;
        do_reset();
        for (int k = 1; k <= 3; k++) begin
            ch_data[31:0] = 32'h100 + k;
            ch_valid = 2'b01;
            tick();
            ch_valid = 2'b00;
            tick();
        end
        checks++; if (if1.count !== 3'd3) begin errors++; $display("FAIL edge_pre_count got %0d exp 3", if1.count); end
        if1.rd_req = 1'b1;
        tick();
        tick();
        checks++; if (if1.count !== 3'd3) begin errors++; $display("FAIL edge_c2_count got %0d exp 3", if1.count); end
        tick();
        checks++; if (if1.count !== 3'd2) begin errors++; $display("FAIL edge_c3_count got %0d exp 2", if1.count); end
        checks++; if (if1.rd_data !== 32'h102) begin errors++; $display("FAIL edge_head got %h exp 102", if1.rd_data); end
        for (int k = 0; k < 7; k++) tick();
        if1.rd_req = 1'b0;
        tick();
        tick();
        tick();
        checks++; if (if1.count !== 3'd2) begin errors++; $display("FAIL edge_hold_count got %0d exp 2", if1.count); end
    endtask

`ifdef TRNG_REPCOUNT_EN
    task automatic test_repcount;
        do_reset();
        ch_data = {32'hDEAD_BEEF, 32'h0};
        for (int k = 0; k < 3; k++) begin
            ch_valid = 2'b10;
            tick();
            ch_valid = 2'b00;
            if (k == 1) begin
                checks++; if (health_fail0 !== 2'b00) begin errors++; $display("FAIL rep_before got %b exp 00", health_fail0); end
            end
            tick();
            tick();
        end
        checks++; if (health_fail0 !== 2'b10) begin errors++; $display("FAIL rep_fail got %b exp 10", health_fail0); end
        if0.rd_req = 1'b1;
        for (int k = 0; k < 6; k++) tick();
        if0.rd_req = 1'b0;
        ch_data = {32'h55, 32'h66};
        ch_valid = 2'b11;
        tick();
        ch_valid = 2'b00;
        tick();
        tick();
        tick();
        checks++; if (if0.count !== 3'd1) begin errors++; $display("FAIL rep_count got %0d exp 1", if0.count); end
        checks++; if (if0.rd_data !== 32'h66) begin errors++; $display("FAIL rep_ch0 got %h exp 66", if0.rd_data); end
        checks++; if (drop_cnt0 !== 16'd0) begin errors++; $display("FAIL rep_drop_cnt got %0d exp 0", drop_cnt0); end
        checks++; if (health_fail0 !== 2'b10) begin errors++; $display("FAIL rep_sticky got %b exp 10", health_fail0); end
    endtask
`endif

    initial begin
        rst = 1'b1;
        ch_valid = '0;
        ch_data = '0;
        if0.rd_req = 1'b0;
        if1.rd_req = 1'b0;
        test_reset();
        test_single_word();
        test_simultaneous();
        test_full_drop();
        test_pop_edge();
`ifdef TRNG_REPCOUNT_EN
        test_repcount();
`endif
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
